change_dispenser: RTL and testbench

//  Drains a latched change total into individual returned coins, largest denomination first.

---
 rtl/change_dispenser.sv | 129 ++++++++++++
 tb/tb_change_dispenser.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Pays out a latched change total as individual coins, largest denomination first,
// one coin per valid/ready handshake; reports done, residual and an unpayable/abort error.
module change_dispenser #(
  parameter int TOTAL_BITS = 31,
  parameter int COIN0_VAL  = 100,
  parameter int COIN1_VAL  = 500,
  parameter int COIN2_VAL  = 1000,
  parameter int CNT_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [TOTAL_BITS-1:0] amount,
  input  logic                  abort,
  input  logic                  coin_ready,
  output logic                  coin_valid,
  output logic [2:0]            coin_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [TOTAL_BITS-1:0] remaining,
  output logic [CNT_BITS-1:0]   coins_out
);

  localparam logic [TOTAL_BITS-1:0] V0 = TOTAL_BITS'(COIN0_VAL);
  localparam logic [TOTAL_BITS-1:0] V1 = TOTAL_BITS'(COIN1_VAL);
  localparam logic [TOTAL_BITS-1:0] V2 = TOTAL_BITS'(COIN2_VAL);

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, FINISH} state_t;

  state_t                state, state_nxt;
  logic [TOTAL_BITS-1:0] rem_nxt, coin_val, rem_sub;
  logic [CNT_BITS-1:0]   cnt_nxt;
  logic [2:0]            sel_nxt;
  logic                  err_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      coins_out <= '0;
      coin_sel  <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= rem_nxt;
      coins_out <= cnt_nxt;
      coin_sel  <= sel_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    coin_val = '0;
    case (coin_sel)
      3'b001:  coin_val = V0;
      3'b010:  coin_val = V1;
      3'b100:  coin_val = V2;
      default: coin_val = '0;
    endcase
  end

  // The selected coin never exceeds remaining, so this cannot underflow.
  assign rem_sub = remaining - coin_val;

  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    cnt_nxt   = coins_out;
    sel_nxt   = coin_sel;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (start) begin
          rem_nxt   = amount;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = SELECT;
        end
      end
      SELECT: begin
        if (abort) begin
          err_nxt   = (remaining != '0);
          state_nxt = FINISH;
        end else if (remaining == '0) begin
          err_nxt   = 1'b0;
          state_nxt = FINISH;
        end else if (remaining >= V2) begin
          sel_nxt   = 3'b100;
          state_nxt = ISSUE;
        end else if (remaining >= V1) begin
          sel_nxt   = 3'b010;
          state_nxt = ISSUE;
        end else if (remaining >= V0) begin
          sel_nxt   = 3'b001;
          state_nxt = ISSUE;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = FINISH;
        end
      end
      ISSUE: begin
        // A handshake coinciding with abort still completes before finishing.
        if (coin_ready) begin
          rem_nxt   = rem_sub;
          cnt_nxt   = (coins_out == '1) ? coins_out : coins_out + CNT_BITS'(1);
          sel_nxt   = 3'b000;
          if (abort) begin
            err_nxt   = (rem_sub != '0);
            state_nxt = FINISH;
          end else begin
            state_nxt = SELECT;
          end
        end else if (abort) begin
          sel_nxt   = 3'b000;
          err_nxt   = (remaining != '0);
          state_nxt = FINISH;
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign coin_valid = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected coin selects are queued per scenario and
// popped on each observed handshake; completion status is checked inline per scenario.
module tb_change_dispenser;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [30:0] amount;
  logic        abort;
  logic        coin_ready;
  logic        coin_valid;
  logic [2:0]  coin_sel;
  logic        busy;
  logic        done;
  logic        err;
  logic [30:0] remaining;
  logic [7:0]  coins_out;

  int errors = 0;
  int checks = 0;
  int valid_cycles = 0;
  int done_cnt = 0;
  logic [2:0] exp_q[$];

  change_dispenser dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount), .abort(abort),
    .coin_ready(coin_ready), .coin_valid(coin_valid), .coin_sel(coin_sel), .busy(busy),
    .done(done), .err(err), .remaining(remaining), .coins_out(coins_out)
  );

  always #5 clk = ~clk;

  // Handshake monitor: every accepted coin must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && done) done_cnt++;
    if (!reset && coin_valid) begin
      valid_cycles++;
      if (coin_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL coin_unexpected: got sel=%b, expected no coin", coin_sel);
        end else begin
          logic [2:0] e;
          e = exp_q.pop_front();
          if (coin_sel !== e) begin
            errors++;
            $display("FAIL coin_sel: got %b, expected %b", coin_sel, e);
          end
        end
      end
    end
  end

  task automatic do_start(input logic [30:0] amt);
    @(posedge clk); #1;
    start  = 1'b1;
    amount = amt;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cycles++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_end(input string name, input bit ok, input logic exp_err,
                           input logic [30:0] exp_rem, input logic [7:0] exp_cnt);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: done not seen, expected done within budget", name);
    end
    checks++;
    if (err !== exp_err || remaining !== exp_rem || coins_out !== exp_cnt) begin
      errors++;
      $display("FAIL %s_status: got err=%b rem=%0d cnt=%0d, expected err=%b rem=%0d cnt=%0d",
               name, err, remaining, coins_out, exp_err, exp_rem, exp_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: got %0d coins outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; amount = '0; abort = 1'b0; coin_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({coin_valid, coin_sel, busy, done, err, remaining, coins_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b sel=%b busy=%b done=%b err=%b rem=%0d cnt=%0d, expected all 0",
               coin_valid, coin_sel, busy, done, err, remaining, coins_out);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_full_pay();
    int cyc; bit ok;
    coin_ready = 1'b1;
    exp_q.push_back(3'b100); exp_q.push_back(3'b010); exp_q.push_back(3'b001);
    do_start(31'd1600);
    wait_done(50, cyc, ok);
    check_end("full_pay", ok, 1'b0, 31'd0, 8'd3);
  endtask

  task automatic test_zero();
    int cyc; bit ok; int v0;
    v0 = valid_cycles;
    do_start(31'd0);
    wait_done(20, cyc, ok);
    checks++;
    if (cyc !== 2 || valid_cycles !== v0) begin
      errors++;
      $display("FAIL zero_latency: got done after %0d cycles, %0d valid cycles, expected 2 and 0",
               cyc, valid_cycles - v0);
    end
    check_end("zero", ok, 1'b0, 31'd0, 8'd0);
  endtask

  task automatic test_residual();
    int cyc; bit ok;
    exp_q.push_back(3'b010); exp_q.push_back(3'b001);
    do_start(31'd650);
    wait_done(50, cyc, ok);
    check_end("residual", ok, 1'b1, 31'd50, 8'd2);
  endtask

  task automatic test_backpressure();
    int cyc; bit ok;
    coin_ready = 1'b0;
    exp_q.push_back(3'b100);
    do_start(31'd1000);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (coin_valid !== 1'b1 || coin_sel !== 3'b100) begin
        errors++;
        $display("FAIL hold_%0d: got valid=%b sel=%b, expected valid=1 sel=100", i, coin_valid, coin_sel);
      end
    end
    @(posedge clk); #1;
    coin_ready = 1'b1;
    wait_done(20, cyc, ok);
    checks++;
    if (coin_valid !== 1'b0 || coin_sel !== 3'b000) begin
      errors++;
      $display("FAIL hold_drop: got valid=%b sel=%b, expected 0 and 000", coin_valid, coin_sel);
    end
    check_end("hold", ok, 1'b0, 31'd0, 8'd1);
  endtask

  task automatic test_abort();
    int cyc; bit ok;
    coin_ready = 1'b1;
    exp_q.push_back(3'b100);
    do_start(31'd2000);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(10, cyc, ok);
    check_end("abort", ok, 1'b1, 31'd1000, 8'd1);
  endtask

  task automatic test_start_while_busy();
    int cyc; bit ok;
    coin_ready = 1'b1;
    exp_q.push_back(3'b100);
    do_start(31'd1000);
    start = 1'b1;
    amount = 31'd500;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(30, cyc, ok);
    check_end("busy_start", ok, 1'b0, 31'd0, 8'd1);
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok; int d0;
    coin_ready = 1'b0;
    do_start(31'd1000);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (coin_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_issue: got valid=%b, expected 1", coin_valid);
    end
    d0 = done_cnt;
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({coin_valid, coin_sel, busy, done, err, remaining, coins_out} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b sel=%b busy=%b done=%b rem=%0d cnt=%0d, expected all 0",
               coin_valid, coin_sel, busy, done, remaining, coins_out);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_nodone: got %0d done pulses busy=%b, expected 0 and 0", done_cnt - d0, busy);
    end
    coin_ready = 1'b1;
    exp_q.push_back(3'b001);
    do_start(31'd100);
    wait_done(20, cyc, ok);
    check_end("after_reset", ok, 1'b0, 31'd0, 8'd1);
  endtask

  initial begin
    test_reset();
    test_full_pay();
    test_zero();
    test_residual();
    test_backpressure();
    test_abort();
    test_start_while_busy();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
